mc_ctrl: RTL and testbench

Multi-cycle MIPS control sequencer. It replaces the single-cycle decoder with a five-state FSM that steps the shared datapath through fetch, decode, execute, memory and write-back phases. Instruction and data memory accesses use a req/ready handshake, and the block counts retired instructions. It sits beside the datapath. Op/Func come from the external IR, which this block loads via IRWr.

---
 rtl/mc_pkg.sv | 87 ++++++++
 rtl/mc_decode.sv | 78 +++++++
 rtl/mc_ctrl.sv | 151 +++++++++++++++
 tb/tb_mc_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer:
// FSM states, datapath select codes, ALU function codes and opcode/funct values.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } mc_state_t;

    localparam logic [2:0] NPC_PC4 = 3'b000;
    localparam logic [2:0] NPC_BEQ = 3'b001;
    localparam logic [2:0] NPC_J   = 3'b010;
    localparam logic [2:0] NPC_BNE = 3'b011;
    localparam logic [2:0] NPC_JR  = 3'b100;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_ADDU = 5'd2;
    localparam logic [4:0] ALU_SUBU = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_SLT  = 5'd5;
    localparam logic [4:0] ALU_SLL  = 5'd6;
    localparam logic [4:0] ALU_SRL  = 5'd7;
    localparam logic [4:0] ALU_SRA  = 5'd8;
    localparam logic [4:0] ALU_LUI  = 5'd9;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        logic r_alu;
        logic i_alu;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
        logic jr;
    } mc_class_t;

    typedef struct packed {
        mc_class_t  cls;
        logic       valid;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] ext_op;
        logic       alu_src1;
        logic       alu_src2;
        logic [4:0] alu_op;
    } mc_dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: Op/Func to a one-hot class and the
// datapath select fields that stay constant while the instruction is in flight.
module mc_decode import mc_pkg::*; #(
    parameter bit JAL_LINK = 1'b1
) (
    input  logic [5:0] op,
    input  logic [5:0] func,
    output mc_dec_t    dec
);

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_ADDU;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADDU: begin dec.cls.r_alu = 1'b1; dec.alu_op = ALU_ADDU; end
                    FN_SUBU: begin dec.cls.r_alu = 1'b1; dec.alu_op = ALU_SUBU; end
                    FN_ADD:  begin dec.cls.r_alu = 1'b1; dec.alu_op = ALU_ADD;  end
                    FN_SUB:  begin dec.cls.r_alu = 1'b1; dec.alu_op = ALU_SUB;  end
                    FN_SLT:  begin dec.cls.r_alu = 1'b1; dec.alu_op = ALU_SLT;  end
                    FN_SLL: begin
                        dec.cls.r_alu = 1'b1; dec.alu_op = ALU_SLL; dec.alu_src2 = 1'b1;
                    end
                    FN_SRL: begin
                        dec.cls.r_alu = 1'b1; dec.alu_op = ALU_SRL; dec.alu_src2 = 1'b1;
                    end
                    FN_SRA: begin
                        dec.cls.r_alu = 1'b1; dec.alu_op = ALU_SRA; dec.alu_src2 = 1'b1;
                    end
                    FN_JR:   dec.cls.jr = 1'b1;
                    default: ;
                endcase
            end
            OP_ORI: begin
                dec.cls.i_alu = 1'b1; dec.alu_op = ALU_OR; dec.alu_src1 = 1'b1;
            end
            OP_LUI: begin
                dec.cls.i_alu = 1'b1; dec.alu_op = ALU_LUI; dec.alu_src1 = 1'b1;
                dec.ext_op    = EXT_LUI;
            end
            OP_ADDI: begin
                dec.cls.i_alu = 1'b1; dec.alu_op = ALU_ADD; dec.alu_src1 = 1'b1;
                dec.ext_op    = EXT_SIGN;
            end
            OP_SLTI: begin
                dec.cls.i_alu = 1'b1; dec.alu_op = ALU_SLT; dec.alu_src1 = 1'b1;
                dec.ext_op    = EXT_SIGN;
            end
            OP_LW: begin
                dec.cls.lw     = 1'b1; dec.alu_src1 = 1'b1; dec.ext_op = EXT_SIGN;
                dec.mem_to_reg = M2R_MEM;
            end
            OP_SW: begin
                dec.cls.sw = 1'b1; dec.alu_src1 = 1'b1; dec.ext_op = EXT_SIGN;
            end
            OP_BEQ: begin
                dec.cls.beq = 1'b1; dec.alu_op = ALU_SUBU; dec.ext_op = EXT_SIGN;
            end
            OP_BNE: begin
                dec.cls.bne = 1'b1; dec.alu_op = ALU_SUBU; dec.ext_op = EXT_SIGN;
            end
            OP_J:    dec.cls.j = 1'b1;
            OP_JAL: begin
                dec.cls.jal = 1'b1;
                if (JAL_LINK) begin
                    dec.reg_dst    = RD_RA;
                    dec.mem_to_reg = M2R_PC4;
                end
            end
            default: ;
        endcase
        if (dec.cls.r_alu)
            dec.reg_dst = RD_RD;
        dec.valid = |dec.cls;
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer: steps the shared datapath through
// IF/ID/EXE/MEM/WB with req/ready memory handshakes and a retired-instruction count.
module mc_ctrl import mc_pkg::*; #(
    parameter int CNT_W    = 32,
    parameter bit JAL_LINK = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Op,
    input  logic [5:0]       Func,
    input  logic             Zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             PCWr,
    output logic             IRWr,
    output logic [2:0]       NPCOp,
    output logic [1:0]       RegDst,
    output logic             RegW,
    output logic             MemW,
    output logic [1:0]       MemToReg,
    output logic             ALUSrc1,
    output logic             ALUSrc2,
    output logic [4:0]       ALUOp,
    output logic [1:0]       EXTOp,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retire_cnt
);

    mc_dec_t   dec;
    mc_state_t cur_st;
    mc_state_t nxt_st;
    logic      retire;

    mc_decode #(.JAL_LINK(JAL_LINK)) u_decode (
        .op   (Op),
        .func (Func),
        .dec  (dec)
    );

    // Next state and retire event; the illegal path returns to IF without retiring.
    always_comb begin
        nxt_st = S_IF;
        retire = 1'b0;
        case (cur_st)
            S_IF: nxt_st = imem_ready ? S_ID : S_IF;
            S_ID: begin
                if (!dec.valid)
                    nxt_st = S_IF;
                else if (dec.cls.j || dec.cls.jal || dec.cls.jr)
                    retire = 1'b1;
                else
                    nxt_st = S_EXE;
            end
            S_EXE: begin
                if (dec.cls.beq || dec.cls.bne)
                    retire = 1'b1;
                else if (dec.cls.lw || dec.cls.sw)
                    nxt_st = S_MEM;
                else
                    nxt_st = S_WB;
            end
            S_MEM: begin
                if (!dmem_ready)
                    nxt_st = S_MEM;
                else if (dec.cls.lw)
                    nxt_st = S_WB;
                else
                    retire = 1'b1;
            end
            S_WB:    retire = 1'b1;
            default: nxt_st = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_st     <= S_IF;
            retire_cnt <= '0;
        end else begin
            cur_st <= nxt_st;
            if (retire)
                retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        RegW     = 1'b0;
        MemW     = 1'b0;
        illegal  = 1'b0;
        NPCOp    = NPC_PC4;
        RegDst   = dec.reg_dst;
        MemToReg = dec.mem_to_reg;
        ALUSrc1  = dec.alu_src1;
        ALUSrc2  = dec.alu_src2;
        ALUOp    = dec.alu_op;
        EXTOp    = dec.ext_op;
        case (cur_st)
            S_IF: begin
                imem_req = 1'b1;
                PCWr     = imem_ready;
                IRWr     = imem_ready;
            end
            S_ID: begin
                if (!dec.valid) begin
                    illegal = 1'b1;
                end else if (dec.cls.j || dec.cls.jal) begin
                    PCWr  = 1'b1;
                    NPCOp = NPC_J;
                    RegW  = dec.cls.jal && JAL_LINK;
                end else if (dec.cls.jr) begin
                    PCWr  = 1'b1;
                    NPCOp = NPC_JR;
                end
            end
            S_EXE: begin
                if (dec.cls.beq) begin
                    NPCOp = NPC_BEQ;
                    PCWr  = Zero;
                end else if (dec.cls.bne) begin
                    NPCOp = NPC_BNE;
                    PCWr  = ~Zero;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                MemW     = dec.cls.sw;
            end
            S_WB:    RegW = 1'b1;
            default: ;
        endcase
        if (rst) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            PCWr     = 1'b0;
            IRWr     = 1'b0;
            RegW     = 1'b0;
            MemW     = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state = cur_st;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: each instruction is expanded into its expected per-cycle
// output trace, the traces are replayed as stimulus and checked every cycle.
module tb_mc_ctrl;
    import mc_pkg::*;

    localparam int CNT_W    = 32;
    localparam bit JAL_LINK = 1'b1;

    localparam bit [3:0] K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4,
                         K_BNE = 5, K_J = 6, K_JAL = 7, K_JR = 8, K_ILL = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] Op = '0, Func = '0;
    logic Zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic imem_req, dmem_req, PCWr, IRWr, RegW, MemW, ALUSrc1, ALUSrc2, illegal;
    logic [2:0] NPCOp, state;
    logic [1:0] RegDst, MemToReg, EXTOp;
    logic [4:0] ALUOp;
    logic [CNT_W-1:0] retire_cnt;

    mc_ctrl #(.CNT_W(CNT_W), .JAL_LINK(JAL_LINK)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Func(Func), .Zero(Zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .PCWr(PCWr), .IRWr(IRWr),
        .NPCOp(NPCOp), .RegDst(RegDst), .RegW(RegW), .MemW(MemW),
        .MemToReg(MemToReg), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2),
        .ALUOp(ALUOp), .EXTOp(EXTOp), .illegal(illegal), .state(state),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit [5:0] op;
        bit [5:0] func;
        bit [3:0] kind;
        bit [1:0] rd;
        bit [1:0] m2r;
        bit [1:0] ext;
        bit       s1;
        bit       s2;
        bit [4:0] alu;
    } instr_t;

    typedef struct {
        bit       rst;
        bit [5:0] op, func;
        bit       ir, dr, zero;
        bit [2:0] st;
        bit       ireq, dreq, pcwr, irwr, regw, memw, ill;
        bit [2:0] npc;
        bit       sel;
        instr_t   ins;
        bit [31:0] cnt;
    } cyc_t;

    instr_t tbl [21];
    cyc_t   q [$];
    cyc_t   cur;
    bit     active = 1'b0;
    int     model_cnt = 0;
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(bit [5:0] op, bit [5:0] fn, bit [3:0] k, bit [1:0] rd,
                                  bit [1:0] m2r, bit [1:0] ext, bit s1, bit s2, bit [4:0] alu);
        instr_t t;
        t.op = op; t.func = fn; t.kind = k; t.rd = rd; t.m2r = m2r;
        t.ext = ext; t.s1 = s1; t.s2 = s2; t.alu = alu;
        return t;
    endfunction

    function automatic cyc_t base(instr_t ins, bit [5:0] fn, bit [2:0] st);
        cyc_t c;
        c = '{default: 0};
        c.op = ins.op; c.func = fn; c.st = st; c.ins = ins;
        c.ir = 1'($urandom); c.dr = 1'($urandom); c.zero = 1'($urandom);
        c.sel = (ins.kind != K_ILL) && (st != 3'd0);
        c.cnt = model_cnt;
        return c;
    endfunction

    // Expected trace of one instruction given fetch/memory wait counts.
    task automatic add_instr(instr_t ins, int wif, int wmem, bit zv, bit abort);
        cyc_t c;
        bit [5:0] fn;
        bit fin = 1'b0;
        fn = (ins.op == 6'h00 && ins.kind != K_ILL) ? ins.func :
             (ins.kind == K_ILL) ? ins.func : 6'($urandom);
        for (int i = 0; i < wif; i++) begin
            c = base(ins, fn, 3'd0); c.ireq = 1; c.ir = 0; q.push_back(c);
        end
        c = base(ins, fn, 3'd0); c.ireq = 1; c.ir = 1; c.pcwr = 1; c.irwr = 1; q.push_back(c);
        c = base(ins, fn, 3'd1);
        case (ins.kind)
            K_J:   begin c.pcwr = 1; c.npc = 3'b010; fin = 1; end
            K_JAL: begin c.pcwr = 1; c.npc = 3'b010; c.regw = JAL_LINK; fin = 1; end
            K_JR:  begin c.pcwr = 1; c.npc = 3'b100; fin = 1; end
            K_ILL: c.ill = 1;
            default: ;
        endcase
        q.push_back(c);
        if (ins.kind == K_ILL) return;
        if (!fin) begin
            c = base(ins, fn, 3'd2); c.zero = zv;
            if (ins.kind == K_BEQ) begin c.npc = 3'b001; c.pcwr = zv;  fin = 1; end
            if (ins.kind == K_BNE) begin c.npc = 3'b011; c.pcwr = !zv; fin = 1; end
            q.push_back(c);
        end
        if (!fin && (ins.kind == K_LW || ins.kind == K_SW)) begin
            for (int i = 0; i < wmem; i++) begin
                c = base(ins, fn, 3'd3); c.dreq = 1; c.memw = (ins.kind == K_SW); c.dr = 0;
                q.push_back(c);
            end
            if (abort) begin
                c = base(ins, fn, 3'd3); c.rst = 1; c.dr = 0; q.push_back(c);
                model_cnt = 0;
                return;
            end
            c = base(ins, fn, 3'd3); c.dreq = 1; c.memw = (ins.kind == K_SW); c.dr = 1;
            q.push_back(c);
            if (ins.kind == K_SW) fin = 1;
        end
        if (!fin) begin
            c = base(ins, fn, 3'd4); c.regw = 1; q.push_back(c);
        end
        model_cnt++;
    endtask

    always @(negedge clk) begin
        if (active) begin
            chk("state", state, cur.st);
            chk("retire_cnt", retire_cnt, cur.cnt);
            chk("imem_req", imem_req, cur.ireq);
            chk("dmem_req", dmem_req, cur.dreq);
            chk("PCWr", PCWr, cur.pcwr);
            chk("IRWr", IRWr, cur.irwr);
            chk("RegW", RegW, cur.regw);
            chk("MemW", MemW, cur.memw);
            chk("illegal", illegal, cur.ill);
            chk("NPCOp", NPCOp, cur.npc);
            if (cur.sel) begin
                chk("RegDst", RegDst, cur.ins.rd);
                chk("MemToReg", MemToReg, cur.ins.m2r);
                chk("EXTOp", EXTOp, cur.ins.ext);
                chk("ALUSrc1", ALUSrc1, cur.ins.s1);
                chk("ALUSrc2", ALUSrc2, cur.ins.s2);
                chk("ALUOp", ALUOp, cur.ins.alu);
            end
        end
    end

    task automatic run_queue();
        while (q.size() > 0) begin
            @(posedge clk); #1;
            cur = q.pop_front();
            rst = cur.rst; Op = cur.op; Func = cur.func;
            imem_ready = cur.ir; dmem_ready = cur.dr; Zero = cur.zero;
            active = 1'b1;
        end
        @(posedge clk); #1;
        active = 1'b0;
        rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n0;
        tbl[0]  = mk(6'h00, 6'h21, K_R,   2'b01, 2'b00, 2'b00, 0, 0, ALU_ADDU);
        tbl[1]  = mk(6'h00, 6'h23, K_R,   2'b01, 2'b00, 2'b00, 0, 0, ALU_SUBU);
        tbl[2]  = mk(6'h00, 6'h20, K_R,   2'b01, 2'b00, 2'b00, 0, 0, ALU_ADD);
        tbl[3]  = mk(6'h00, 6'h22, K_R,   2'b01, 2'b00, 2'b00, 0, 0, ALU_SUB);
        tbl[4]  = mk(6'h00, 6'h2A, K_R,   2'b01, 2'b00, 2'b00, 0, 0, ALU_SLT);
        tbl[5]  = mk(6'h00, 6'h00, K_R,   2'b01, 2'b00, 2'b00, 0, 1, ALU_SLL);
        tbl[6]  = mk(6'h00, 6'h02, K_R,   2'b01, 2'b00, 2'b00, 0, 1, ALU_SRL);
        tbl[7]  = mk(6'h00, 6'h03, K_R,   2'b01, 2'b00, 2'b00, 0, 1, ALU_SRA);
        tbl[8]  = mk(6'h00, 6'h08, K_JR,  2'b00, 2'b00, 2'b00, 0, 0, ALU_ADDU);
        tbl[9]  = mk(6'h0D, 6'h00, K_I,   2'b00, 2'b00, 2'b00, 1, 0, ALU_OR);
        tbl[10] = mk(6'h0F, 6'h00, K_I,   2'b00, 2'b00, 2'b10, 1, 0, ALU_LUI);
        tbl[11] = mk(6'h08, 6'h00, K_I,   2'b00, 2'b00, 2'b01, 1, 0, ALU_ADD);
        tbl[12] = mk(6'h0A, 6'h00, K_I,   2'b00, 2'b00, 2'b01, 1, 0, ALU_SLT);
        tbl[13] = mk(6'h23, 6'h00, K_LW,  2'b00, 2'b01, 2'b01, 1, 0, ALU_ADDU);
        tbl[14] = mk(6'h2B, 6'h00, K_SW,  2'b00, 2'b00, 2'b01, 1, 0, ALU_ADDU);
        tbl[15] = mk(6'h04, 6'h00, K_BEQ, 2'b00, 2'b00, 2'b01, 0, 0, ALU_SUBU);
        tbl[16] = mk(6'h05, 6'h00, K_BNE, 2'b00, 2'b00, 2'b01, 0, 0, ALU_SUBU);
        tbl[17] = mk(6'h02, 6'h00, K_J,   2'b00, 2'b00, 2'b00, 0, 0, ALU_ADDU);
        tbl[18] = mk(6'h03, 6'h00, K_JAL, 2'b10, 2'b10, 2'b00, 0, 0, ALU_ADDU);
        tbl[19] = mk(6'h3F, 6'h00, K_ILL, 2'b00, 2'b00, 2'b00, 0, 0, ALU_ADD);
        tbl[20] = mk(6'h00, 6'h3F, K_ILL, 2'b00, 2'b00, 2'b00, 0, 0, ALU_ADD);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", state, 0);
        chk("reset_cnt", retire_cnt, 0);
        chk("reset_imem_req", imem_req, 0);

        n0 = q.size(); add_instr(tbl[0], 0, 0, 0, 0);  chk("len_addu", q.size() - n0, 4);
        n0 = q.size(); add_instr(tbl[13], 0, 3, 0, 0); chk("len_lw_wait3", q.size() - n0, 8);
        n0 = q.size(); add_instr(tbl[15], 0, 0, 1, 0); chk("len_beq", q.size() - n0, 3);
        n0 = q.size(); add_instr(tbl[16], 0, 0, 1, 0); chk("len_bne", q.size() - n0, 3);
        n0 = q.size(); add_instr(tbl[18], 0, 0, 0, 0); chk("len_jal", q.size() - n0, 2);
        n0 = q.size(); add_instr(tbl[19], 0, 0, 0, 0); chk("len_illegal", q.size() - n0, 2);
        run_queue();
        chk("directed_cnt", retire_cnt, 5);
        chk("directed_state", state, 0);

        add_instr(tbl[14], 1, 1, 0, 1);
        add_instr(tbl[0], 0, 0, 0, 0);
        run_queue();
        chk("after_reset_cnt", retire_cnt, 1);

        for (int n = 0; n < 300; n++) begin
            int idx;
            bit ab;
            idx = $urandom_range(0, 20);
            ab  = (tbl[idx].kind == K_LW || tbl[idx].kind == K_SW) && ($urandom_range(0, 39) == 0);
            add_instr(tbl[idx], $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), ab);
        end
        run_queue();
        chk("final_cnt", retire_cnt, model_cnt);
        chk("final_state", state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
